// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master. A simple command/response port is
// converted into one AXI4-Lite write or read at a time; every output is a
// register loaded from the next-state logic.
module axi_lite_master #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_axi_reset,
  // command port
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_we,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  // response port
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                    o_rsp_resp,
  // AXI write address channel
  output logic                          o_axi_awvalid,
  input  logic                          i_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_awaddr,
  // AXI write data channel
  output logic                          o_axi_wvalid,
  input  logic                          i_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_axi_wstrb,
  // AXI write response channel
  input  logic                          i_axi_bvalid,
  output logic                          o_axi_bready,
  input  logic [1:0]                    i_axi_bresp,
  // AXI read address channel
  output logic                          o_axi_arvalid,
  input  logic                          i_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_araddr,
  // AXI read data channel
  input  logic                          i_axi_rvalid,
  output logic                          o_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]                    i_axi_rresp
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

  state_t                      state_q;
  state_t                      state_d;

  logic                        cmd_ready_d;
  logic                        rsp_valid_d;
  logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata_d;
  logic [1:0]                  rsp_resp_d;
  logic                        awvalid_d;
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr_d;
  logic                        wvalid_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_d;
  logic [STRB_W-1:0]           wstrb_d;
  logic                        bready_d;
  logic                        arvalid_d;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr_d;
  logic                        rready_d;

  // Next-state and next-output logic; every register holds its value by default.
  // Ready/valid flags that belong to a whole state are derived from state_d so
  // they are already high in the first cycle of that state.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = o_rsp_rdata;
    rsp_resp_d  = o_rsp_resp;
    awvalid_d   = o_axi_awvalid;
    awaddr_d    = o_axi_awaddr;
    wvalid_d    = o_axi_wvalid;
    wdata_d     = o_axi_wdata;
    wstrb_d     = o_axi_wstrb;
    arvalid_d   = o_axi_arvalid;
    araddr_d    = o_axi_araddr;

    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          if (i_cmd_we) begin
            state_d   = WADDR_DATA;
            awvalid_d = 1'b1;
            awaddr_d  = i_cmd_addr;
            wvalid_d  = 1'b1;
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
            araddr_d  = i_cmd_addr;
          end
        end
      end
      // AW and W retire independently; leave once neither is still pending,
      // which also covers both handshaking on the same edge.
      WADDR_DATA: begin
        if (o_axi_awvalid && i_axi_awready) awvalid_d = 1'b0;
        if (o_axi_wvalid && i_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)        state_d   = WRESP;
      end
      WRESP: begin
        if (o_axi_bready && i_axi_bvalid) begin
          state_d     = RSP;
          rsp_resp_d  = i_axi_bresp;
          rsp_rdata_d = '0;
        end
      end
      RADDR: begin
        if (o_axi_arvalid && i_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (o_axi_rready && i_axi_rvalid) begin
          state_d     = RSP;
          rsp_rdata_d = i_axi_rdata;
          rsp_resp_d  = i_axi_rresp;
        end
      end
      RSP: begin
        if (o_rsp_valid && i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    bready_d    = (state_d == WRESP);
    rready_d    = (state_d == RDATA);
    rsp_valid_d = (state_d == RSP);
  end

  // State and output registers with synchronous reset clearing everything.
  always_ff @(posedge i_clk) begin
    if (i_axi_reset) begin
      state_q       <= IDLE;
      o_cmd_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= '0;
      o_axi_awvalid <= 1'b0;
      o_axi_awaddr  <= '0;
      o_axi_wvalid  <= 1'b0;
      o_axi_wdata   <= '0;
      o_axi_wstrb   <= '0;
      o_axi_bready  <= 1'b0;
      o_axi_arvalid <= 1'b0;
      o_axi_araddr  <= '0;
      o_axi_rready  <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_cmd_ready   <= cmd_ready_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_rdata   <= rsp_rdata_d;
      o_rsp_resp    <= rsp_resp_d;
      o_axi_awvalid <= awvalid_d;
      o_axi_awaddr  <= awaddr_d;
      o_axi_wvalid  <= wvalid_d;
      o_axi_wdata   <= wdata_d;
      o_axi_wstrb   <= wstrb_d;
      o_axi_bready  <= bready_d;
      o_axi_arvalid <= arvalid_d;
      o_axi_araddr  <= araddr_d;
      o_axi_rready  <= rready_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a directed vector table, a block of
// random transactions checked against a memory-level reference model, and a
// reset-in-WRESP sequence. A behavioural AXI-Lite slave with programmable
// per-channel wait states lives inside the bench.
module tb_axi_lite_master;

  logic        i_clk;
  logic        i_axi_reset;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_we;
  logic [3:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic        o_axi_awvalid;
  logic        i_axi_awready;
  logic [3:0]  o_axi_awaddr;
  logic        o_axi_wvalid;
  logic        i_axi_wready;
  logic [31:0] o_axi_wdata;
  logic [3:0]  o_axi_wstrb;
  logic        i_axi_bvalid;
  logic        o_axi_bready;
  logic [1:0]  i_axi_bresp;
  logic        o_axi_arvalid;
  logic        i_axi_arready;
  logic [3:0]  o_axi_araddr;
  logic        i_axi_rvalid;
  logic        o_axi_rready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;

  axi_lite_master #(
    .C_AXI_DATA_WIDTH(32),
    .C_AXI_ADDR_WIDTH(4)
  ) dut (
    .i_clk         (i_clk),
    .i_axi_reset   (i_axi_reset),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_we      (i_cmd_we),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wdata   (i_cmd_wdata),
    .i_cmd_wstrb   (i_cmd_wstrb),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_resp    (o_rsp_resp),
    .o_axi_awvalid (o_axi_awvalid),
    .i_axi_awready (i_axi_awready),
    .o_axi_awaddr  (o_axi_awaddr),
    .o_axi_wvalid  (o_axi_wvalid),
    .i_axi_wready  (i_axi_wready),
    .o_axi_wdata   (o_axi_wdata),
    .o_axi_wstrb   (o_axi_wstrb),
    .i_axi_bvalid  (i_axi_bvalid),
    .o_axi_bready  (o_axi_bready),
    .i_axi_bresp   (i_axi_bresp),
    .o_axi_arvalid (o_axi_arvalid),
    .i_axi_arready (i_axi_arready),
    .o_axi_araddr  (o_axi_araddr),
    .i_axi_rvalid  (i_axi_rvalid),
    .o_axi_rready  (o_axi_rready),
    .i_axi_rdata   (i_axi_rdata),
    .i_axi_rresp   (i_axi_rresp)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // OR of every DUT output, for "everything is zero" checks.
  logic any_out;
  assign any_out = |{o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp,
                     o_axi_awvalid, o_axi_awaddr, o_axi_wvalid, o_axi_wdata,
                     o_axi_wstrb, o_axi_bready, o_axi_arvalid, o_axi_araddr,
                     o_axi_rready};

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [4];
  logic [31:0] ref_mem   [4];

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd, wd, bd, ard, rd, rspd;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic mem_write(input bit to_ref, input logic [3:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    for (int j = 0; j < 4; j++) begin
      if (strb[j]) begin
        if (to_ref) ref_mem[addr[3:2]][8*j +: 8] = data[8*j +: 8];
        else        slave_mem[addr[3:2]][8*j +: 8] = data[8*j +: 8];
      end
    end
  endtask

  task automatic idle_slave();
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    i_axi_bvalid  = 1'b0;
    i_axi_bresp   = 2'b00;
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b0;
    i_axi_rdata   = '0;
    i_axi_rresp   = 2'b00;
    i_rsp_ready   = 1'b0;
  endtask

  // One command through the DUT. Called at #1 after a rising edge. Cycle 1 is
  // the cycle right after the accepting edge; g_lat is the first cycle that
  // shows o_rsp_valid. Slave waits: a channel's ready/valid comes after the
  // given number of cycles of waiting.
  task automatic run_txn(input bit we, input logic [3:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int awd, input int wd, input int bd,
                         input int ard, input int rd, input int rspd, input logic [1:0] sresp,
                         output logic [31:0] g_rdata, output logic [1:0] g_resp,
                         output int g_lat, output int g_aw, output int g_w,
                         output int g_rspc, output bit stable_ok);
    int          cyc, aw_wait, w_wait, ar_wait, b_wait, r_wait, rsp_wait;
    bit          aw_done, w_done, ar_done, b_done, r_done, done;
    logic [3:0]  aw_cap, ar_cap;
    logic [31:0] wd_cap;
    logic [3:0]  ws_cap;
    check("cmd_ready_before_cmd", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_addr  = addr;
    i_cmd_wdata = wdata;
    i_cmd_wstrb = wstrb;
    @(posedge i_clk); #1;
    // scramble the command bus so unlatched use of it shows up
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 4'($urandom);
    i_cmd_wdata = $urandom;
    i_cmd_wstrb = 4'($urandom);
    i_cmd_we    = 1'($urandom);
    cyc = 1; done = 0; stable_ok = 1;
    g_lat = -1; g_aw = 0; g_w = 0; g_rspc = 0; g_rdata = '0; g_resp = '0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; rsp_wait = 0;
    aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
    aw_cap = '0; ar_cap = '0; wd_cap = '0; ws_cap = '0;
    while (!done && cyc < 100) begin
      if (o_axi_awvalid) begin
        g_aw++;
        if (o_axi_awaddr !== addr) stable_ok = 0;
      end
      if (o_axi_wvalid) begin
        g_w++;
        if (o_axi_wdata !== wdata || o_axi_wstrb !== wstrb) stable_ok = 0;
      end
      if (o_axi_arvalid && o_axi_araddr !== addr) stable_ok = 0;
      if (o_cmd_ready) stable_ok = 0;
      if (o_rsp_valid) begin
        if (g_rspc == 0) begin
          g_lat = cyc; g_rdata = o_rsp_rdata; g_resp = o_rsp_resp;
        end else if (o_rsp_rdata !== g_rdata || o_rsp_resp !== g_resp) begin
          stable_ok = 0;
        end
        g_rspc++;
      end
      i_axi_awready = o_axi_awvalid && (aw_wait >= awd);
      if (o_axi_awvalid && !i_axi_awready) aw_wait++;
      i_axi_wready = o_axi_wvalid && (w_wait >= wd);
      if (o_axi_wvalid && !i_axi_wready) w_wait++;
      i_axi_arready = o_axi_arvalid && (ar_wait >= ard);
      if (o_axi_arvalid && !i_axi_arready) ar_wait++;
      i_axi_bvalid = aw_done && w_done && !b_done && (b_wait >= bd);
      i_axi_bresp  = sresp;
      if (aw_done && w_done && !b_done && !i_axi_bvalid) b_wait++;
      i_axi_rvalid = ar_done && !r_done && (r_wait >= rd);
      i_axi_rdata  = i_axi_rvalid ? slave_mem[ar_cap[3:2]] : $urandom;
      i_axi_rresp  = sresp;
      if (ar_done && !r_done && !i_axi_rvalid) r_wait++;
      i_rsp_ready = o_rsp_valid && (rsp_wait >= rspd);
      if (o_rsp_valid && !i_rsp_ready) rsp_wait++;
      if (o_axi_awvalid && i_axi_awready) begin aw_done = 1; aw_cap = o_axi_awaddr; end
      if (o_axi_wvalid && i_axi_wready) begin
        w_done = 1; wd_cap = o_axi_wdata; ws_cap = o_axi_wstrb;
      end
      if (o_axi_arvalid && i_axi_arready) begin ar_done = 1; ar_cap = o_axi_araddr; end
      if (i_axi_bvalid && o_axi_bready) begin
        b_done = 1;
        mem_write(0, aw_cap, wd_cap, ws_cap);
      end
      if (i_axi_rvalid && o_axi_rready) r_done = 1;
      if (o_rsp_valid && i_rsp_ready) done = 1;
      @(posedge i_clk); #1;
      cyc++;
    end
    idle_slave();
    if (!done) check("txn_timeout", 1, 0);
    check("cmd_ready_after_rsp", {o_cmd_ready, o_rsp_valid}, 2'b10);
  endtask

  logic [31:0] g_rdata;
  logic [1:0]  g_resp;
  int          g_lat, g_aw, g_w, g_rspc;
  bit          stable_ok;

  initial begin
    vecs[0] = '{1, 4'h8, 32'hDEADBEEF, 4'hF,   0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        2'b00, 3};
    vecs[1] = '{0, 4'h8, 32'h0,        4'h0,   0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00, 3};
    vecs[2] = '{1, 4'h4, 32'h12345678, 4'hF,   3, 0, 0, 0, 0, 0, 2'b00, 32'h0,        2'b00, 6};
    vecs[3] = '{0, 4'h4, 32'h0,        4'h0,   0, 0, 0, 0, 0, 0, 2'b10, 32'h12345678, 2'b10, 3};
    vecs[4] = '{1, 4'h8, 32'hA5A5A5A5, 4'b0101,0, 0, 2, 0, 0, 0, 2'b10, 32'h0,        2'b10, 5};
    vecs[5] = '{0, 4'h8, 32'h0,        4'h0,   0, 0, 0, 2, 1, 5, 2'b11, 32'hDEA5BEA5, 2'b11, 6};
    vecs[6] = '{1, 4'h0, 32'h11223344, 4'hF,   1, 4, 0, 0, 0, 0, 2'b11, 32'h0,        2'b11, 7};
    vecs[7] = '{0, 4'h0, 32'h0,        4'h0,   0, 0, 0, 0, 0, 0, 2'b01, 32'h11223344, 2'b01, 3};

    for (int i = 0; i < 4; i++) begin
      slave_mem[i] = '0;
      ref_mem[i]   = '0;
    end

    i_axi_reset = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_wdata = '0;
    i_cmd_wstrb = '0;
    idle_slave();

    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs_zero", any_out, 0);
    i_axi_reset = 1'b0;
    @(posedge i_clk); #1;
    check("cmd_ready_after_reset", o_cmd_ready, 1);

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].awd,
              vecs[i].wd, vecs[i].bd, vecs[i].ard, vecs[i].rd, vecs[i].rspd, vecs[i].resp,
              g_rdata, g_resp, g_lat, g_aw, g_w, g_rspc, stable_ok);
      if (vecs[i].we) mem_write(1, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      check($sformatf("vec%0d_latency", i), g_lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_resp", i), g_resp, vecs[i].exp_resp);
      check($sformatf("vec%0d_stable", i), stable_ok, 1);
      check($sformatf("vec%0d_rsp_cycles", i), g_rspc, vecs[i].rspd + 1);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_aw_cycles", i), g_aw, vecs[i].awd + 1);
        check($sformatf("vec%0d_w_cycles", i), g_w, vecs[i].wd + 1);
      end
    end

    // randomized transactions against the memory-level reference
    for (int i = 0; i < 40; i++) begin
      bit          we;
      logic [3:0]  addr, strb;
      logic [31:0] data, exp_rdata;
      logic [1:0]  resp;
      int          awd, wd, bd, ard, rd, rspd, exp_lat;
      we   = 1'($urandom);
      addr = 4'($urandom);
      data = $urandom;
      strb = 4'($urandom);
      resp = 2'($urandom);
      awd  = $urandom_range(0, 3);
      wd   = $urandom_range(0, 3);
      bd   = $urandom_range(0, 3);
      ard  = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      rspd = $urandom_range(0, 3);
      exp_rdata = we ? 32'h0 : ref_mem[addr[3:2]];
      exp_lat   = we ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd;
      run_txn(we, addr, data, strb, awd, wd, bd, ard, rd, rspd, resp,
              g_rdata, g_resp, g_lat, g_aw, g_w, g_rspc, stable_ok);
      if (we) mem_write(1, addr, data, strb);
      check($sformatf("rnd%0d_latency", i), g_lat, exp_lat);
      check($sformatf("rnd%0d_rdata", i), g_rdata, exp_rdata);
      check($sformatf("rnd%0d_resp", i), g_resp, resp);
      check($sformatf("rnd%0d_stable", i), stable_ok, 1);
    end
    for (int i = 0; i < 4; i++) check($sformatf("mem%0d", i), slave_mem[i], ref_mem[i]);

    // reset while waiting for the write response
    i_cmd_valid   = 1'b1;
    i_cmd_we      = 1'b1;
    i_cmd_addr    = 4'hC;
    i_cmd_wdata   = 32'hCAFEF00D;
    i_cmd_wstrb   = 4'hF;
    i_axi_awready = 1'b1;
    i_axi_wready  = 1'b1;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    check("r19_aw_w_valid", {o_axi_awvalid, o_axi_wvalid}, 2'b11);
    @(posedge i_clk); #1;
    check("r19_in_wresp", {o_axi_bready, o_axi_awvalid, o_axi_wvalid}, 3'b100);
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    i_axi_reset   = 1'b1;
    @(posedge i_clk); #1;
    check("r19_reset_outputs_zero", any_out, 0);
    i_axi_reset  = 1'b0;
    i_axi_bvalid = 1'b1;
    @(posedge i_clk); #1;
    check("r19_cmd_ready_after_reset", {o_cmd_ready, o_rsp_valid, o_axi_bready}, 3'b100);
    repeat (3) begin
      @(posedge i_clk); #1;
      check("r19_no_response", {o_rsp_valid, o_axi_bready}, 2'b00);
    end
    i_axi_bvalid = 1'b0;

    // normal operation resumes after the abandoned write
    run_txn(0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00,
            g_rdata, g_resp, g_lat, g_aw, g_w, g_rspc, stable_ok);
    check("post_reset_read_latency", g_lat, 3);
    check("post_reset_read_data", g_rdata, ref_mem[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI data width in bits (multiple of 8).
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 4, AXI byte-address width.
REQ-003 SHALL have ports, one per line as: name direction width meaning.
- i_clk in 1 single system clock; all logic on rising edge.
- i_axi_reset in 1 reset, synchronous, active-high.
- i_cmd_valid in 1 command request.
- o_cmd_ready out 1 command accepted when high with i_cmd_valid.
- i_cmd_we in 1 1=write, 0=read.
- i_cmd_addr in C_AXI_ADDR_WIDTH target address.
- i_cmd_wdata in C_AXI_DATA_WIDTH write data.
- i_cmd_wstrb in C_AXI_DATA_WIDTH/8 write byte strobes.
- o_rsp_valid out 1 response available.
- i_rsp_ready in 1 response consumed when high with o_rsp_valid.
- o_rsp_rdata out C_AXI_DATA_WIDTH read data (0 for writes).
- o_rsp_resp out 2 AXI response code.
- o_axi_awvalid out 1 write address valid.
- i_axi_awready in 1 write address ready.
- o_axi_awaddr out C_AXI_ADDR_WIDTH write address.
- o_axi_wvalid out 1 write data valid.
- i_axi_wready in 1 write data ready.
- o_axi_wdata out C_AXI_DATA_WIDTH write data.
- o_axi_wstrb out C_AXI_DATA_WIDTH/8 write strobes.
- i_axi_bvalid in 1 write response valid.
- o_axi_bready out 1 write response ready.
- i_axi_bresp in 2 write response.
- o_axi_arvalid out 1 read address valid.
- i_axi_arready in 1 read address ready.
- o_axi_araddr out C_AXI_ADDR_WIDTH read address.
- i_axi_rvalid in 1 read data valid.
- o_axi_rready out 1 read data ready.
- i_axi_rdata in C_AXI_DATA_WIDTH read data.
- i_axi_rresp in 2 read response.

Function
REQ-004 SHALL implement a single-outstanding AXI4-Lite master with FSM states IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP; all outputs registered.
REQ-005 IDLE: o_cmd_ready=1; on i_cmd_valid, latch addr/wdata/wstrb/we and go to WADDR_DATA (we=1) or RADDR (we=0); o_cmd_ready=0 in every other state.
REQ-006 WADDR_DATA: awvalid and wvalid both rise the cycle after command acceptance; each drops independently the cycle after its own handshake; go to WRESP once both handshakes have completed, including when both complete in the same cycle.
REQ-007 AW and W payloads SHALL be held stable while their valid is high; a valid SHALL never drop before its handshake.
REQ-008 WRESP: o_axi_bready=1; on i_axi_bvalid, capture bresp into o_rsp_resp, set o_rsp_rdata=0, go to RSP; bvalid arriving before WRESP is ignored (bready=0).
REQ-009 RADDR: arvalid=1 until arready, then RDATA; RDATA: o_axi_rready=1; on i_axi_rvalid, capture rdata/rresp, go to RSP.
REQ-010 RSP: o_rsp_valid=1 with stable data; on i_rsp_ready go to IDLE; the next command is accepted no earlier than the following cycle.
REQ-011 Minimum write latency, command accept (cycle N) to o_rsp_valid: N+3 with zero-wait slave; read: N+3.
REQ-012 SLVERR/DECERR responses SHALL be passed through unchanged; no retry.

Reset
REQ-013 While i_axi_reset=1 at a clock edge: FSM->IDLE; all valid/ready outputs, o_rsp_rdata, o_rsp_resp, and address/data/strobe outputs = 0; o_cmd_ready=0.
REQ-014 Reset mid-transaction SHALL abandon it with no response; o_cmd_ready=1 the first cycle after reset deasserts.

Verification
REQ-015 Write addr 4'h8, data 32'hDEADBEEF, strb 4'hF, zero-wait slave, bresp 0 -> AW/W valid at N+1, o_rsp_valid at N+3, o_rsp_resp=0.
REQ-016 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable addr, single response.
REQ-017 Read addr 4'h4, slave returns 32'h12345678 rresp 2'b10 -> o_rsp_rdata=32'h12345678, o_rsp_resp=2'b10.
REQ-018 i_rsp_ready low for 5 cycles -> o_rsp_valid and data held, o_cmd_ready=0 throughout; new command accepted only after release.
REQ-019 Assert reset while in WRESP -> all outputs 0 next edge, no o_rsp_valid, o_cmd_ready=1 the cycle after reset drops.
